ntom_req_arbiter: RTL

Parametrised successor of the 8-to-2 request arbiter in the vector cache controller. It picks up to GRANT_NUM requests per cycle from REQ_NUM requesters using a round-robin pointer. Each grant is paired with one MSHR allocation lane, and the granted group goes into a registered output stage with a group valid/ready handshake. Unlike the previous block, it has fair rotation, a ready for each requester and each allocation lane, partial-group grants and an output register that absorbs backpressure.

---
 rtl/ntom_req_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ntom_req_arbiter.sv
// Round-robin N-to-M request arbiter: binds up to GRANT_NUM valid requesters to
// in-order MSHR allocation lanes and holds the granted group in an output register.
module ntom_req_arbiter #(
  parameter int REQ_NUM         = 8,
  parameter int GRANT_NUM       = 2,
  parameter int ENTRY_IDX_WIDTH = 4,
  parameter int PLD_WIDTH       = 32,
  localparam int SRC_W          = (REQ_NUM < 2) ? 1 : $clog2(REQ_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [REQ_NUM-1:0]                   v_req_vld,
  input  logic [REQ_NUM*PLD_WIDTH-1:0]         v_req_pld,
  output logic [REQ_NUM-1:0]                   v_req_rdy,
  input  logic [GRANT_NUM-1:0]                 v_mshr_alloc_vld,
  input  logic [GRANT_NUM*ENTRY_IDX_WIDTH-1:0] v_mshr_alloc_idx,
  output logic [GRANT_NUM-1:0]                 v_mshr_alloc_rdy,
  output logic [GRANT_NUM-1:0]                 v_out_vld,
  output logic [GRANT_NUM*PLD_WIDTH-1:0]       v_out_pld,
  output logic [GRANT_NUM*ENTRY_IDX_WIDTH-1:0] v_out_mshr_idx,
  output logic [GRANT_NUM*SRC_W-1:0]           v_out_src_id,
  input  logic                                 out_rdy
);

  if (REQ_NUM < 2 || GRANT_NUM < 1 || GRANT_NUM > REQ_NUM) begin : g_param_check
    $error("ntom_req_arbiter: illegal REQ_NUM/GRANT_NUM combination");
  end

  logic [SRC_W-1:0]                                r_rr_ptr;
  logic [GRANT_NUM-1:0]                            r_out_vld;
  logic [GRANT_NUM-1:0][PLD_WIDTH-1:0]             r_out_pld;
  logic [GRANT_NUM-1:0][ENTRY_IDX_WIDTH-1:0]       r_out_idx;
  logic [GRANT_NUM-1:0][SRC_W-1:0]                 r_out_src;

  logic [REQ_NUM-1:0]                              w_vld_rot;
  logic [REQ_NUM-1:0]                              w_sel_rot;
  logic [REQ_NUM-1:0]                              w_sel;
  logic [GRANT_NUM-1:0]                            w_lane_used;
  logic [GRANT_NUM-1:0][SRC_W-1:0]                 w_lane_src;
  logic [GRANT_NUM-1:0][PLD_WIDTH-1:0]             w_lane_pld;
  logic [GRANT_NUM-1:0][ENTRY_IDX_WIDTH-1:0]       w_lane_idx;
  logic [SRC_W-1:0]                                w_last_src;
  logic [SRC_W-1:0]                                w_next_ptr;
  logic                                            w_stage_free;
  logic                                            w_load;

  // Rotate so that bit 0 is the requester at rr_ptr; un-rotate the selection back.
  assign w_vld_rot = REQ_NUM'({v_req_vld, v_req_vld} >> r_rr_ptr);
  assign w_sel     = REQ_NUM'(({w_sel_rot, w_sel_rot} << r_rr_ptr) >> REQ_NUM);

  // Capacity is the contiguous prefix of offered lanes; scan requesters in rotated order.
  always_comb begin : b_scan
    int   cap;
    int   cnt;
    int   src_i;
    logic run;
    logic hit_k;
    cap         = 32'sd0;
    cnt         = 32'sd0;
    src_i       = 32'sd0;
    run         = 1'b1;
    hit_k       = 1'b0;
    w_sel_rot   = {REQ_NUM{1'b0}};
    w_lane_used = {GRANT_NUM{1'b0}};
    w_lane_src  = {(GRANT_NUM*SRC_W){1'b0}};
    w_last_src  = r_rr_ptr;
    for (int j = 0; j < GRANT_NUM; j++) begin
      run = run & v_mshr_alloc_vld[j];
      cap = cap + int'(run);
    end
    for (int k = 0; k < REQ_NUM; k++) begin
      hit_k        = w_vld_rot[k] && (cnt < cap);
      src_i        = int'(r_rr_ptr) + k;
      src_i        = (src_i >= REQ_NUM) ? (src_i - REQ_NUM) : src_i;
      w_sel_rot[k] = hit_k;
      for (int j = 0; j < GRANT_NUM; j++) begin
        w_lane_used[j] = w_lane_used[j] | (hit_k && (cnt == j));
        w_lane_src[j]  = (hit_k && (cnt == j)) ? SRC_W'(src_i) : w_lane_src[j];
      end
      w_last_src = hit_k ? SRC_W'(src_i) : w_last_src;
      cnt        = cnt + int'(hit_k);
    end
  end

  // Steer the selected requester payload and the lane's offered entry into each lane.
  always_comb begin : b_lane_data
    w_lane_pld = {(GRANT_NUM*PLD_WIDTH){1'b0}};
    w_lane_idx = {(GRANT_NUM*ENTRY_IDX_WIDTH){1'b0}};
    for (int j = 0; j < GRANT_NUM; j++) begin
      w_lane_idx[j] = {ENTRY_IDX_WIDTH{w_lane_used[j]}} &
                      v_mshr_alloc_idx[j*ENTRY_IDX_WIDTH +: ENTRY_IDX_WIDTH];
      for (int i = 0; i < REQ_NUM; i++) begin
        w_lane_pld[j] = w_lane_pld[j] |
                        ({PLD_WIDTH{w_lane_used[j] && (w_lane_src[j] == SRC_W'(i))}} &
                         v_req_pld[i*PLD_WIDTH +: PLD_WIDTH]);
      end
    end
  end

  assign w_next_ptr   = (w_last_src == SRC_W'(REQ_NUM-1)) ? {SRC_W{1'b0}} : (w_last_src + SRC_W'(1));
  assign w_stage_free = ~(|r_out_vld) | out_rdy;
  // rst_n gating keeps every ready low while reset is held.
  assign w_load       = rst_n & w_stage_free & (|w_lane_used);

  assign v_req_rdy        = w_load ? w_sel       : {REQ_NUM{1'b0}};
  assign v_mshr_alloc_rdy = w_load ? w_lane_used : {GRANT_NUM{1'b0}};

  // Output group register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= {GRANT_NUM{1'b0}};
      r_out_pld <= {(GRANT_NUM*PLD_WIDTH){1'b0}};
      r_out_idx <= {(GRANT_NUM*ENTRY_IDX_WIDTH){1'b0}};
      r_out_src <= {(GRANT_NUM*SRC_W){1'b0}};
      r_rr_ptr  <= {SRC_W{1'b0}};
    end else if (w_load) begin
      r_out_vld <= w_lane_used;
      r_out_pld <= w_lane_pld;
      r_out_idx <= w_lane_idx;
      r_out_src <= w_lane_src;
      r_rr_ptr  <= w_next_ptr;
    end else if (out_rdy) begin
      r_out_vld <= {GRANT_NUM{1'b0}};
    end
  end

  assign v_out_vld      = r_out_vld;
  assign v_out_pld      = r_out_pld;
  assign v_out_mshr_idx = r_out_idx;
  assign v_out_src_id   = r_out_src;

endmodule
